// File: rtl/d_branch_ctrl_pkg.sv
// Shared definitions for the D-stage branch sequencer: comparator op codes,
// FSM state encoding and the single-source Tnew hazard test.
package d_branch_ctrl_pkg;

    typedef enum logic [1:0] {
        BRC_IDLE = 2'd0,
        BRC_WAIT = 2'd1,
        BRC_SLOT = 2'd2
    } brc_state_e;

    localparam logic [2:0] CMP_EQ  = 3'd0;
    localparam logic [2:0] CMP_NE  = 3'd1;
    localparam logic [2:0] CMP_LEZ = 3'd2;
    localparam logic [2:0] CMP_GTZ = 3'd3;
    localparam logic [2:0] CMP_LTZ = 3'd4;
    localparam logic [2:0] CMP_GEZ = 3'd5;
    // D_CMP yields 0 for this code, so an idle comparator never jumps.
    localparam logic [2:0] CMP_NOP = 3'd7;

    // Branch Tuse is 0: any in-flight writer with Tnew > 0 is a hazard.
    function automatic logic src_hazard(input logic [4:0] src,
                                        input logic [4:0] a3,
                                        input logic [1:0] tnew);
        return (src != 5'd0) && (src == a3) && (tnew != 2'd0);
    endfunction

endpackage

// File: rtl/d_br_hazard.sv
// Combinational rs/rt versus E/M Tnew hazard check for a Tuse=0 consumer.
module d_br_hazard
    import d_branch_ctrl_pkg::*;
(
    input  logic       chk_en,
    input  logic [4:0] rs,
    input  logic [4:0] rt,
    input  logic [4:0] e_a3,
    input  logic [1:0] e_tnew,
    input  logic [4:0] m_a3,
    input  logic [1:0] m_tnew,
    output logic       hazard
);

    logic rs_hz;
    logic rt_hz;

    assign rs_hz  = src_hazard(rs, e_a3, e_tnew) | src_hazard(rs, m_a3, m_tnew);
    assign rt_hz  = src_hazard(rt, e_a3, e_tnew) | src_hazard(rt, m_a3, m_tnew);
    assign hazard = chk_en & (rs_hz | rt_hz);

endmodule

// File: rtl/d_branch_ctrl.sv
// Decode-stage branch sequencer: holds hazarded branches, resolves the NPC
// select, tracks the delay slot and counts events. Option: BRANCH_LIKELY_EN.
module d_branch_ctrl
    import d_branch_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             d_valid,
    input  logic             d_is_br,
    input  logic             d_likely,
    input  logic [2:0]       d_cmp_op,
    input  logic [4:0]       d_rs,
    input  logic [4:0]       d_rt,
    input  logic [4:0]       e_a3,
    input  logic [1:0]       e_tnew,
    input  logic [4:0]       m_a3,
    input  logic [1:0]       m_tnew,
    output logic [2:0]       cmp_op,
    input  logic             cmp_jump,
    output logic             stall,
    output logic             npc_br,
    output logic             ds_flag,
    output logic             ds_annul,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    brc_state_e state, state_nxt;
    logic       br_in_d;
    logic       hazard;
    logic       resolve;
    logic       annul;

    assign br_in_d = d_valid & d_is_br;

    d_br_hazard u_hazard (
        .chk_en (br_in_d),
        .rs     (d_rs),
        .rt     (d_rt),
        .e_a3   (e_a3),
        .e_tnew (e_tnew),
        .m_a3   (m_a3),
        .m_tnew (m_tnew),
        .hazard (hazard)
    );

    assign cmp_op = br_in_d ? d_cmp_op : CMP_NOP;

    // Outputs are gated by reset so an in-flight stall drops the instant reset falls.
    assign resolve = reset & br_in_d & ~hazard;

`ifdef BRANCH_LIKELY_EN
    assign annul = resolve & d_likely & ~cmp_jump;
`else
    logic unused_likely;
    assign unused_likely = d_likely;
    assign annul         = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= BRC_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = BRC_IDLE;
        stall     = 1'b0;
        npc_br    = 1'b0;
        ds_annul  = 1'b0;
        if (reset && br_in_d) begin
            if (hazard) begin
                stall = 1'b1;
                // A branch held in the slot keeps the slot marking until D moves.
                state_nxt = (state == BRC_SLOT) ? BRC_SLOT : BRC_WAIT;
            end else begin
                npc_br    = cmp_jump;
                ds_annul  = annul;
                state_nxt = annul ? BRC_IDLE : BRC_SLOT;
            end
        end
    end

    assign ds_flag = (state == BRC_SLOT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            br_cnt    <= '0;
            taken_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (resolve)            br_cnt    <= br_cnt + 1'b1;
            if (resolve & cmp_jump) taken_cnt <= taken_cnt + 1'b1;
            if (stall)              stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_d_branch_ctrl.sv
// Directed bench for d_branch_ctrl with a cycle-level reference model and
// literal spot checks; honours BRANCH_LIKELY_EN if defined.
module tb_d_branch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        d_valid, d_is_br, d_likely, cmp_jump;
    logic [2:0]  d_cmp_op, cmp_op;
    logic [4:0]  d_rs, d_rt, e_a3, m_a3;
    logic [1:0]  e_tnew, m_tnew;
    logic        stall, npc_br, ds_flag, ds_annul;
    logic [31:0] br_cnt, taken_cnt, stall_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    d_branch_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .d_valid(d_valid), .d_is_br(d_is_br),
        .d_likely(d_likely), .d_cmp_op(d_cmp_op), .d_rs(d_rs), .d_rt(d_rt),
        .e_a3(e_a3), .e_tnew(e_tnew), .m_a3(m_a3), .m_tnew(m_tnew),
        .cmp_op(cmp_op), .cmp_jump(cmp_jump), .stall(stall), .npc_br(npc_br),
        .ds_flag(ds_flag), .ds_annul(ds_annul), .br_cnt(br_cnt),
        .taken_cnt(taken_cnt), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: ds_flag and counters as plain state, everything else
    // derived from the current inputs each cycle.
    logic        m_ds, m_ds_n;
    logic [31:0] m_br, m_tk, m_st, m_br_n, m_tk_n, m_st_n;

    always @(negedge clk) begin
        bit br, hz, res, ann;
        if (!reset) begin
            chk("rst_stall", stall, 0);
            chk("rst_npc", npc_br, 0);
            chk("rst_ds_flag", ds_flag, 0);
            chk("rst_annul", ds_annul, 0);
            chk("rst_br_cnt", br_cnt, 0);
            chk("rst_taken_cnt", taken_cnt, 0);
            chk("rst_stall_cnt", stall_cnt, 0);
            m_ds_n = 0; m_br_n = 0; m_tk_n = 0; m_st_n = 0;
        end else begin
            br = d_valid && d_is_br;
            hz = br && ((d_rs != 0 && ((d_rs == e_a3 && e_tnew > 0) || (d_rs == m_a3 && m_tnew > 0))) ||
                        (d_rt != 0 && ((d_rt == e_a3 && e_tnew > 0) || (d_rt == m_a3 && m_tnew > 0))));
            res = br && !hz;
`ifdef BRANCH_LIKELY_EN
            ann = res && d_likely && !cmp_jump;
`else
            ann = 0;
`endif
            chk("cmp_op", cmp_op, br ? d_cmp_op : 3'd7);
            chk("stall", stall, hz);
            chk("npc_br", npc_br, res && cmp_jump);
            chk("ds_annul", ds_annul, ann);
            chk("ds_flag", ds_flag, m_ds);
            chk("br_cnt", br_cnt, m_br);
            chk("taken_cnt", taken_cnt, m_tk);
            chk("stall_cnt", stall_cnt, m_st);
            m_ds_n = res ? !ann : (hz ? m_ds : 1'b0);
            m_br_n = m_br + (res ? 1 : 0);
            m_tk_n = m_tk + ((res && cmp_jump) ? 1 : 0);
            m_st_n = m_st + (hz ? 1 : 0);
        end
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_ds <= 0; m_br <= 0; m_tk <= 0; m_st <= 0;
        end else begin
            m_ds <= m_ds_n; m_br <= m_br_n; m_tk <= m_tk_n; m_st <= m_st_n;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        d_valid = 1; d_is_br = 0; d_likely = 0; d_cmp_op = 3'd0; cmp_jump = 0;
        d_rs = 0; d_rt = 0; e_a3 = 0; e_tnew = 0; m_a3 = 0; m_tnew = 0;
    endtask

    task automatic branch(input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt,
                          input logic jump, input logic likely);
        d_valid = 1; d_is_br = 1; d_cmp_op = op; d_rs = rs; d_rt = rt;
        cmp_jump = jump; d_likely = likely;
    endtask

    logic [31:0] br0, st0;

    initial begin
        reset = 0;
        quiet();
        cyc(); cyc();
        reset = 1;
        cyc();

        // Hazard-free taken beq on $5,$5
        branch(3'd0, 5'd5, 5'd5, 1, 0);
        #1 chk("t1_npc_same_cycle", npc_br, 1);
        chk("t1_no_stall", stall, 0);
        cyc();
        quiet();
        chk("t1_ds_flag", ds_flag, 1);
        chk("t1_br_cnt", br_cnt, 1);
        chk("t1_taken_cnt", taken_cnt, 1);
        cyc();
        chk("t1_slot_exit", ds_flag, 0);

        // Load-use on rs: lw in E (tnew 2), then M (tnew 1), then gone
        st0 = stall_cnt;
        branch(3'd0, 5'd8, 5'd0, 0, 0);
        e_a3 = 5'd8; e_tnew = 2'd2;
        #1 chk("t2_stall_c1", stall, 1);
        cyc();
        e_a3 = 0; e_tnew = 0; m_a3 = 5'd8; m_tnew = 2'd1;
        #1 chk("t2_stall_c2", stall, 1);
        cyc();
        m_a3 = 0; m_tnew = 0;
        #1 chk("t2_resolve_no_stall", stall, 0);
        cyc();
        quiet();
        chk("t2_stall_cnt", stall_cnt - st0, 2);
        chk("t2_ds_flag", ds_flag, 1);
        cyc();

        // $0 source with E writing $0
        branch(3'd1, 5'd0, 5'd0, 1, 0);
        e_a3 = 5'd0; e_tnew = 2'd1;
        #1 chk("t3_zero_no_stall", stall, 0);
        cyc();
        quiet();
        cyc();

        // rt hazard against M
        branch(3'd1, 5'd3, 5'd9, 1, 0);
        m_a3 = 5'd9; m_tnew = 2'd1;
        cyc();
        m_a3 = 0; m_tnew = 0;
        cyc();
        quiet();
        cyc();

        // Not-taken likely branch
        branch(3'd0, 5'd4, 5'd6, 0, 1);
`ifdef BRANCH_LIKELY_EN
        #1 chk("t5_annul", ds_annul, 1);
        cyc();
        quiet();
        chk("t5_ds_flag", ds_flag, 0);
`else
        #1 chk("t5_annul_tied", ds_annul, 0);
        cyc();
        quiet();
        chk("t5_ds_flag", ds_flag, 1);
`endif
        cyc();

        // Flush while waiting: no count
        br0 = br_cnt;
        branch(3'd0, 5'd7, 5'd0, 1, 0);
        e_a3 = 5'd7; e_tnew = 2'd1;
        cyc();
        d_valid = 0;
        cyc();
        quiet();
        chk("t6_flush_no_count", br_cnt, br0);
        cyc();

        // Branch in the delay slot resolves again, including a held one
        branch(3'd2, 5'd1, 5'd0, 1, 0);
        cyc();
        branch(3'd3, 5'd2, 5'd0, 0, 0);
        m_a3 = 5'd2; m_tnew = 2'd1;
        cyc();
        chk("t7_slot_held", ds_flag, 1);
        m_a3 = 0; m_tnew = 0;
        cyc();
        quiet();
        cyc();
        cyc();

        // Reset during WAIT
        branch(3'd0, 5'd8, 5'd0, 1, 0);
        e_a3 = 5'd8; e_tnew = 2'd2;
        cyc();
        #2 reset = 0;
        #1 chk("t8_stall_drop", stall, 0);
        chk("t8_br_cnt", br_cnt, 0);
        chk("t8_taken_cnt", taken_cnt, 0);
        chk("t8_stall_cnt", stall_cnt, 0);
        cyc();
        quiet();
        reset = 1;
        cyc(); cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
